// File: rtl/tb_uart_pkg.sv
// tb_uart_pkg: definitions shared by the tb_uart transmitter and receiver.
//   uart_state_e : frame phase, used by both the TX and RX state machines
//   DATA_BITS    : data bits per frame (8N1)
//   STOP_BITS    : stop bits per frame
//   LAST_BIT     : index of the final data bit, as held in a 3-bit bit counter
package tb_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int         DATA_BITS = 8;
   localparam int         STOP_BITS = 1;
   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

endpackage

// File: rtl/tb_uart_rx.sv
// tb_uart_rx: 8N1 receiver for bytes arriving from the chip's TX pin.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   ser_rx     : asynchronous serial input, idle high
//   rx_finish  : one-cycle pulse when a frame with a valid stop bit completes
//   rx_data    : last valid byte, updated in the rx_finish cycle
//
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronized line
// START | counting to the start-bit midpoint; high there means false start
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit; low discards the byte
module tb_uart_rx
   import tb_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4167
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ser_rx,
   output logic       rx_finish,
   output logic [7:0] rx_data
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   uart_state_e   rx_state;
   logic [CW-1:0] rx_baud;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_sync1;
   logic          rx_sync2;
   logic          rx_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync1  <= 1'b1;
         rx_sync2  <= 1'b1;
         rx_prev   <= 1'b1;
         rx_state  <= IDLE;
         rx_baud   <= '0;
         rx_bit    <= '0;
         rx_shift  <= '0;
         rx_finish <= 1'b0;
         rx_data   <= '0;
      end else begin
         rx_sync1  <= ser_rx;
         rx_sync2  <= rx_sync1;
         rx_prev   <= rx_sync2;
         rx_finish <= 1'b0;
         case (rx_state)
            // Edge detect only: after a framing error the line is still low,
            // so no new start is seen until it has gone back high.
            IDLE: begin
               if (!rx_sync2 && rx_prev) begin
                  rx_state <= START;
                  rx_baud  <= '0;
               end
            end
            START: begin
               if (rx_baud == BAUD_HALF) begin
                  rx_baud <= '0;
                  rx_bit  <= '0;
                  rx_state <= rx_sync2 ? IDLE : DATA;
               end else begin
                  rx_baud <= rx_baud + 1'b1;
               end
            end
            DATA: begin
               if (rx_baud == BAUD_LAST) begin
                  rx_baud  <= '0;
                  rx_shift <= {rx_sync2, rx_shift[7:1]};
                  if (rx_bit == LAST_BIT) rx_state <= STOP;
                  else                    rx_bit   <= rx_bit + 1'b1;
               end else begin
                  rx_baud <= rx_baud + 1'b1;
               end
            end
            // Leave at the stop-bit midpoint so a back-to-back start edge is caught.
            STOP: begin
               if (rx_baud == BAUD_LAST) begin
                  rx_baud  <= '0;
                  rx_state <= IDLE;
                  if (rx_sync2) begin
                     rx_data   <= rx_shift;
                     rx_finish <= 1'b1;
                  end
               end else begin
                  rx_baud <= rx_baud + 1'b1;
               end
            end
            default: rx_state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/tb_uart.sv
// tb_uart: testbench-side 8N1 serial port facing the chip's user UART pins.
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   tx_start     : transmit request, acted on at its rising edge
//   tx_data      : byte to send, latched on accept
//   ser_tx       : serial output to the chip's RX pin, idle high
//   tx_busy      : high from accept until the stop bit ends
//   tx_finish    : one-cycle pulse after the last stop-bit cycle
//   tx_clear_req : high after a finished frame until tx_start is seen low
//   ser_rx       : serial input from the chip's TX pin (asynchronous)
//   rx_finish    : one-cycle pulse per valid received frame
//   rx_data      : last valid received byte
//
// state | meaning
// IDLE  | line high, waiting for an accepted request
// START | driving the start bit (0)
// DATA  | driving 8 data bits, LSB first
// STOP  | driving the stop bit (1)
module tb_uart
   import tb_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4167
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       ser_tx,
   output logic       tx_busy,
   output logic       tx_finish,
   output logic       tx_clear_req,
   input  logic       ser_rx,
   output logic       rx_finish,
   output logic [7:0] rx_data
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   uart_state_e   tx_state;
   logic [CW-1:0] tx_baud;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;
   logic          tx_start_q;
   logic          tx_accept;

   // Rising edge only; a held or re-raised request while busy/uncleared is dropped.
   assign tx_accept = tx_start && !tx_start_q && (tx_state == IDLE) && !tx_clear_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state     <= IDLE;
         tx_baud      <= '0;
         tx_bit       <= '0;
         tx_shift     <= '0;
         tx_start_q   <= 1'b0;
         ser_tx       <= 1'b1;
         tx_busy      <= 1'b0;
         tx_finish    <= 1'b0;
         tx_clear_req <= 1'b0;
      end else begin
         tx_start_q <= tx_start;
         tx_finish  <= 1'b0;
         if (!tx_start) tx_clear_req <= 1'b0;
         case (tx_state)
            IDLE: begin
               if (tx_accept) begin
                  tx_state <= START;
                  tx_shift <= tx_data;
                  tx_baud  <= '0;
                  tx_bit   <= '0;
                  ser_tx   <= 1'b0;
                  tx_busy  <= 1'b1;
               end
            end
            START: begin
               if (tx_baud == BAUD_LAST) begin
                  tx_baud  <= '0;
                  tx_state <= DATA;
                  ser_tx   <= tx_shift[0];
               end else begin
                  tx_baud <= tx_baud + 1'b1;
               end
            end
            DATA: begin
               if (tx_baud == BAUD_LAST) begin
                  tx_baud <= '0;
                  if (tx_bit == LAST_BIT) begin
                     tx_state <= STOP;
                     ser_tx   <= 1'b1;
                  end else begin
                     tx_bit   <= tx_bit + 1'b1;
                     tx_shift <= tx_shift >> 1;
                     ser_tx   <= tx_shift[1];
                  end
               end else begin
                  tx_baud <= tx_baud + 1'b1;
               end
            end
            // Completion sets clear_req after the tx_start-low clear above,
            // so a request still held high keeps it set.
            STOP: begin
               if (tx_baud == BAUD_LAST) begin
                  tx_baud      <= '0;
                  tx_state     <= IDLE;
                  tx_busy      <= 1'b0;
                  tx_finish    <= 1'b1;
                  tx_clear_req <= 1'b1;
               end else begin
                  tx_baud <= tx_baud + 1'b1;
               end
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

   tb_uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .ser_rx    (ser_rx),
      .rx_finish (rx_finish),
      .rx_data   (rx_data)
   );

endmodule

// File: tb/tb_tb_uart.sv
// tb_tb_uart: directed, table-driven check of tb_uart with CLKS_PER_BIT = 4.
module tb_tb_uart;

   localparam int CPB = 4;

   logic       clk;
   logic       rst;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       ser_tx;
   logic       tx_busy;
   logic       tx_finish;
   logic       tx_clear_req;
   logic       ser_rx;
   logic       rx_finish;
   logic [7:0] rx_data;

   logic       loop_en;
   logic       rx_line;

   int         n_vec;
   int         n_err;
   int         rx_cnt;
   logic [7:0] rx_last;

   // data, frame bits (bit 0 goes out first), expected received byte, cycles to hold tx_start after finish
   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
      logic [7:0] exp_rx;
      int         hold;
   } tx_vec_t;

   tx_vec_t vecs[6];

   assign ser_rx = loop_en ? ser_tx : rx_line;

   tb_uart #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .ser_tx       (ser_tx),
      .tx_busy      (tx_busy),
      .tx_finish    (tx_finish),
      .tx_clear_req (tx_clear_req),
      .ser_rx       (ser_rx),
      .rx_finish    (rx_finish),
      .rx_data      (rx_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_finish) begin
         rx_cnt  = rx_cnt + 1;
         rx_last = rx_data;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [9:0] fr, input logic [7:0] exp_rx, input int hold);
      int rx_before;
      rx_before = rx_cnt;
      @(negedge clk);
      tx_data  = d;
      tx_start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < CPB; j++) begin
            @(negedge clk);
            check("tx_bit", 32'({ser_tx, tx_busy, tx_finish}), 32'({fr[i], 2'b10}));
         end
      end
      @(negedge clk);
      check("tx_end", 32'({ser_tx, tx_busy, tx_finish, tx_clear_req}), 32'h0000_000B);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("tx_hold", 32'({ser_tx, tx_busy, tx_finish, tx_clear_req}), 32'h0000_0009);
      end
      tx_start = 1'b0;
      @(negedge clk);
      check("tx_clear", 32'(tx_clear_req), 32'd0);
      repeat (2) @(negedge clk);
      check("rx_count", 32'(rx_cnt - rx_before), 32'd1);
      check("rx_data", 32'(rx_last), 32'(exp_rx));
   endtask

   task automatic drive_rx_frame(input logic [9:0] fr);
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < CPB; j++) begin
            @(negedge clk);
            rx_line = fr[i];
         end
      end
      @(negedge clk);
      rx_line = 1'b1;
   endtask

   initial begin
      int rx_before;

      vecs[0] = '{8'h0F, 10'h21E, 8'h0F, 10};
      vecs[1] = '{8'h3D, 10'h27A, 8'h3D, 0};
      vecs[2] = '{8'h4F, 10'h29E, 8'h4F, 0};
      vecs[3] = '{8'h00, 10'h200, 8'h00, 0};
      vecs[4] = '{8'hFF, 10'h3FE, 8'hFF, 0};
      vecs[5] = '{8'hA5, 10'h34A, 8'hA5, 0};

      n_vec    = 0;
      n_err    = 0;
      rx_cnt   = 0;
      rx_last  = 8'h00;
      rst      = 1'b1;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      loop_en  = 1'b1;
      rx_line  = 1'b1;

      repeat (2) @(negedge clk);
      check("reset_outs", 32'({ser_tx, tx_busy, tx_finish, tx_clear_req, rx_finish}), 32'h0000_0010);
      check("reset_rx_data", 32'(rx_data), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 5 * CPB; i++) begin
         @(negedge clk);
         check("idle", 32'({ser_tx, tx_busy, tx_finish, tx_clear_req, rx_finish}), 32'h0000_0010);
      end

      for (int v = 0; v < 6; v++)
         send_frame(vecs[v].data, vecs[v].frame, vecs[v].exp_rx, vecs[v].hold);

      // receiver robustness, driven directly
      loop_en = 1'b0;
      repeat (4) @(negedge clk);

      rx_before = rx_cnt;
      @(negedge clk);
      rx_line = 1'b0;
      @(negedge clk);
      rx_line = 1'b1;
      repeat (50) @(negedge clk);
      check("rx_glitch_count", 32'(rx_cnt - rx_before), 32'd0);

      drive_rx_frame(10'h0AA);
      repeat (3 * CPB) @(negedge clk);
      check("rx_frame_err_count", 32'(rx_cnt - rx_before), 32'd0);
      check("rx_frame_err_data", 32'(rx_data), 32'(vecs[5].exp_rx));

      drive_rx_frame(10'h29E);
      repeat (3 * CPB) @(negedge clk);
      check("rx_after_err_count", 32'(rx_cnt - rx_before), 32'd1);
      check("rx_after_err_data", 32'(rx_data), 32'h0000_004F);

      // reset in the middle of a transmission
      loop_en = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk);
      tx_data  = 8'hA5;
      tx_start = 1'b1;
      repeat (4 * CPB + 2) @(negedge clk);
      check("mid_tx_busy", 32'(tx_busy), 32'd1);
      rst      = 1'b1;
      tx_start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("mid_reset_outs", 32'({ser_tx, tx_busy, tx_finish, tx_clear_req}), 32'h0000_0008);
      check("mid_reset_rx_data", 32'(rx_data), 32'd0);
      for (int i = 0; i < 3 * CPB; i++) begin
         @(negedge clk);
         check("post_reset_idle", 32'({ser_tx, tx_busy}), 32'h0000_0002);
      end
      send_frame(8'h3D, 10'h27A, 8'h3D, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tb_uart.md
# tb_uart

Cycle-accurate, synthesizable model of the testbench-side serial port, 8N1, that sits on the chip's user UART pins. It drives bytes into the chip's receive pin on request. It decodes bytes arriving on the chip's transmit pin and flags each completed frame. Transmitter and receiver are independent and may run concurrently.

## Interface
Parameters:
- CLKS_PER_BIT, default 4167: clock cycles per serial bit (40 MHz / 9600 baud).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_start  in  1  request to transmit tx_data; acted on at its rising edge.
- tx_data  in  8  byte to send; latched when a request is accepted.
- ser_tx  out  1  serial output to the chip's RX pin; idle high.
- tx_busy  out  1  high from request accept until the stop bit ends.
- tx_finish  out  1  one-cycle pulse at the end of each stop bit.
- tx_clear_req  out  1  high after a finished transmission until tx_start is seen low.
- ser_rx  in  1  serial input from the chip's TX pin; asynchronous.
- rx_finish  out  1  one-cycle pulse when a valid frame is received.
- rx_data  out  8  last valid received byte; updated in the rx_finish cycle.

## Operation
- Frame format: 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- TX states: IDLE → START → DATA (8 bits) → STOP → IDLE.
  - A request is accepted when tx_start=1, the registered previous tx_start=0, and the state is IDLE with tx_clear_req=0.
  - On accept: latch tx_data, enter START.
  - On STOP completion: pulse tx_finish, drop tx_busy, set tx_clear_req.
  - tx_clear_req clears on the first cycle tx_start=0. No new request is accepted while it is set.
  - Rising edges of tx_start while busy are ignored, not queued.
- RX states: IDLE → START → DATA → STOP → IDLE.
  - ser_rx passes through a 2-flop synchronizer before any use.
  - IDLE: a 1→0 transition on the synchronized line enters START.
  - START: the line is re-sampled at CLKS_PER_BIT/2. If it is 1, this is a false start; return to IDLE.
  - DATA: sample each data bit at mid-bit, i.e. CLKS_PER_BIT after the previous sample.
  - STOP: sample at mid-bit.
    - If 1: update rx_data, pulse rx_finish, return to IDLE.
    - If 0 (framing error): discard the byte, no rx_finish, and wait in IDLE for the line to return to 1 before re-arming.
  - The receiver returns to IDLE at the stop-bit mid-point so that back-to-back frames are caught.
- Reset values:
  - ser_tx=1; tx_busy, tx_finish, tx_clear_req, rx_finish = 0; rx_data=0.
  - Both FSMs in IDLE; bit and baud counters = 0.
  - Synchronizer flops = 1.
- Reset mid-frame aborts immediately; ser_tx returns high on the next cycle.

## Timing
- Request accept at edge N: tx_busy=1 and ser_tx=0 from edge N+1.
- The start bit occupies cycles N+1 .. N+CLKS_PER_BIT.
- The whole frame is 10·CLKS_PER_BIT cycles. tx_finish is high in the cycle after the last stop-bit cycle; tx_busy is 0 in that same cycle.
- RX latency: 2 synchronizer cycles + edge detect. rx_finish fires ≈9.5·CLKS_PER_BIT+3 cycles after the falling edge on ser_rx.
- Baud counters wrap from CLKS_PER_BIT-1 to 0. Bit index is 3 bits; it leaves DATA after index 7.
- Counter widths are $clog2(CLKS_PER_BIT).
- The TX and RX paths are fully independent; simultaneous events on both need no arbitration.

## Structure
- Shared package tb_uart_pkg holds:
  - the 2-bit state enum (IDLE, START, DATA, STOP), used by both TX and RX;
  - the frame-length constants (8 data bits, 1 stop bit).
- One sub-module, tb_uart_rx: synchronizer, receive FSM, rx_data/rx_finish.
- The transmitter and the tx_start edge/clear logic stay in the top module.
- Total is roughly 150–250 lines.

## Test plan
- Reset, then idle: ser_tx=1, tx_busy=0, and no pulses on any output for 5·CLKS_PER_BIT cycles.
- TX single byte (CLKS_PER_BIT=4):
  - Stimulus: tx_data=0x0F, raise tx_start.
  - ser_tx bit sequence is 0,1,1,1,1,0,0,0,0,1, each bit 4 cycles.
  - tx_busy is high for 40 cycles, then tx_finish pulses once.
  - tx_clear_req stays high until tx_start drops; holding tx_start high produces no second frame.
- Back-to-back TX:
  - Send 0x0F, 0x3D, 0x4F, each a fresh tx_start rising edge issued after tx_finish.
  - Exactly three frames with the correct bits; no gap longer than 2 cycles beyond the handshake.
- RX loopback: connect ser_tx to ser_rx and send 0x3D → one rx_finish pulse with rx_data=0x3D.
- RX robustness:
  - A 1-cycle glitch low on ser_rx → no rx_finish.
  - A frame with stop bit=0 → no rx_finish, and rx_data unchanged.
  - A following valid 0x4F frame is received correctly.
- Reset mid-TX (asserted in bit 4):
  - ser_tx=1 and tx_busy=0 the next cycle.
  - A subsequent rising edge of tx_start sends a complete, correct frame.
